// File: rtl/reg_op_sequencer_if.sv
// reg_op_sequencer_if
// Bundles everything that passes between the sequencer, its two requesters
// and the shared load/shift register.
//   Requester side (per requester N = 0/1):
//     reqN_valid, reqN_op[1:0], reqN_data[WIDTH-1:0], reqN_count[COUNT_W-1:0]
//     go into the sequencer; reqN_ready comes back out.
//   Register side: reg_data_out goes into the sequencer; reg_data_in and
//     reg_control[2:0] come out of it.
//   Status: busy, done, done_id and result[WIDTH-1:0] come out of the sequencer.
// Modports: slave is the sequencer's view; master is the environment's view
// (the requesters plus the register).
interface reg_op_sequencer_if #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 3
);
  logic               req0_valid;
  logic [1:0]         req0_op;
  logic [WIDTH-1:0]   req0_data;
  logic [COUNT_W-1:0] req0_count;
  logic               req0_ready;

  logic               req1_valid;
  logic [1:0]         req1_op;
  logic [WIDTH-1:0]   req1_data;
  logic [COUNT_W-1:0] req1_count;
  logic               req1_ready;

  logic [WIDTH-1:0]   reg_data_out;
  logic [WIDTH-1:0]   reg_data_in;
  logic [2:0]         reg_control;

  logic               busy;
  logic               done;
  logic               done_id;
  logic [WIDTH-1:0]   result;

  // The sequencer sees the requests and the register value, and drives
  // everything else.
  modport slave (
    input  req0_valid, req0_op, req0_data, req0_count,
    input  req1_valid, req1_op, req1_data, req1_count,
    input  reg_data_out,
    output req0_ready, req1_ready,
    output reg_data_in, reg_control,
    output busy, done, done_id, result
  );

  // The environment is the mirror image of the sequencer.
  modport master (
    output req0_valid, req0_op, req0_data, req0_count,
    output req1_valid, req1_op, req1_data, req1_count,
    output reg_data_out,
    input  req0_ready, req1_ready,
    input  reg_data_in, reg_control,
    input  busy, done, done_id, result
  );
endinterface

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer
// Shares one external 4-bit load/shift register between two requesters.
// Each job is "load a value, then shift or rotate it N times". Requesters are
// arbitrated round-robin, the register is driven one control code per cycle,
// and the register's value is handed back as the job result.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - reg_op_sequencer_if.slave: requester handshakes, register
//          data_in/control/data_out, and busy/done/done_id/result status
module reg_op_sequencer #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_op_sequencer_if.slave    bus
);

  localparam logic [2:0] CTRL_HOLD = 3'd0;
  localparam logic [2:0] CTRL_LOAD = 3'd1;
  localparam logic [2:0] CTRL_SHL  = 3'd2;
  localparam logic [2:0] CTRL_SHR  = 3'd3;
  localparam logic [2:0] CTRL_ROL  = 3'd4;

  localparam logic [1:0] OP_LOAD_ONLY = 2'b00;
  localparam logic [1:0] OP_SHL       = 2'b01;
  localparam logic [1:0] OP_SHR       = 2'b10;
  localparam logic [1:0] OP_ROL       = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   data_q;
  logic [COUNT_W-1:0] cnt_q;
  logic               id_q;
  logic               last_grant_q;
  logic               grant0;
  logic               grant1;

  // Round-robin arbitration, only ever active in IDLE. last_grant_q holds the
  // id of the requester granted most recently; on a tie the other one wins.
  // Grants are suppressed while rst is high so a requester never sees a
  // handshake that the reset is about to discard.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (bus.req0_valid && (!bus.req1_valid || last_grant_q)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // State register plus the job fields captured at the grant edge. The step
  // counter takes the requested count at the grant, so it already holds it
  // in LOAD, and counts down once per issued shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      id_q         <= 1'b0;
    end else begin
      state <= state_next;
      if (grant0 || grant1) begin
        op_q         <= grant1 ? bus.req1_op    : bus.req0_op;
        data_q       <= grant1 ? bus.req1_data  : bus.req0_data;
        cnt_q        <= grant1 ? bus.req1_count : bus.req0_count;
        id_q         <= grant1;
        last_grant_q <= grant1;
      end else if (state == SHIFT) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Next-state and per-cycle register drive. SHIFT exits in the cycle the
  // counter reads 1, which makes the number of shift cycles equal the count.
  always_comb begin
    state_next      = state;
    bus.reg_control = CTRL_HOLD;
    bus.reg_data_in = '0;
    bus.req0_ready  = grant0;
    bus.req1_ready  = grant1;
    bus.busy        = (state != IDLE);
    bus.done        = 1'b0;
    bus.done_id     = 1'b0;
    bus.result      = '0;
    case (state)
      IDLE: begin
        if (grant0 || grant1) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        bus.reg_control = CTRL_LOAD;
        bus.reg_data_in = data_q;
        if (op_q != OP_LOAD_ONLY && cnt_q != '0) begin
          state_next = SHIFT;
        end else begin
          state_next = DONE;
        end
      end
      SHIFT: begin
        case (op_q)
          OP_SHL:  bus.reg_control = CTRL_SHL;
          OP_SHR:  bus.reg_control = CTRL_SHR;
          OP_ROL:  bus.reg_control = CTRL_ROL;
          default: bus.reg_control = CTRL_HOLD;
        endcase
        if (cnt_q == COUNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.done    = 1'b1;
        bus.done_id = id_q;
        bus.result  = bus.reg_data_out;
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// tb_reg_op_sequencer
// Directed bench for reg_op_sequencer. A behavioural model of the external
// 4-bit load/shift register closes the loop from reg_control/reg_data_in back
// to reg_data_out. Inputs are driven just after the falling edge and outputs
// are read there, away from the rising edge.
module tb_reg_op_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] reg_q = 4'b0000;

  int vectors = 0;
  int miscompares = 0;

  reg_op_sequencer_if #(.WIDTH(4), .COUNT_W(3)) bus ();

  reg_op_sequencer #(.WIDTH(4), .COUNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External register model: acts on the control code at each rising edge.
  always @(posedge clk) begin
    case (bus.reg_control)
      3'd1:    reg_q <= bus.reg_data_in;
      3'd2:    reg_q <= {reg_q[2:0], 1'b0};
      3'd3:    reg_q <= {1'b0, reg_q[3:1]};
      3'd4:    reg_q <= {reg_q[2:0], reg_q[3]};
      default: reg_q <= reg_q;
    endcase
  end
  assign bus.reg_data_out = reg_q;

  // Whole-run guard so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_data = 4'h0; bus.req0_count = 3'd0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_data = 4'h0; bus.req1_count = 3'd0;
  endtask

  task automatic set_req0(input logic [1:0] op, input logic [3:0] data, input logic [2:0] count);
    bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_data = data; bus.req0_count = count;
  endtask

  task automatic set_req1(input logic [1:0] op, input logic [3:0] data, input logic [2:0] count);
    bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_data = data; bus.req1_count = count;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    set_req0(2'b01, 4'hF, 3'd1);
    tick();
    tick();
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    vectors++; if (bus.reg_control !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_ctrl: got %0d expected 0", bus.reg_control); end
    vectors++; if (bus.reg_data_in !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_data_in: got %b expected 0000", bus.reg_data_in); end
    vectors++; if (bus.req0_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready0: got %b expected 0", bus.req0_ready); end
    vectors++; if (bus.result !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_result: got %b expected 0000", bus.result); end
    clear_reqs();
    rst = 1'b0;
  endtask

  task automatic test_shl();
    set_req0(2'b01, 4'b1011, 3'd1);
    #1;
    vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL shl_ready0: got %b expected 1", bus.req0_ready); end
    vectors++; if (bus.req1_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL shl_ready1: got %b expected 0", bus.req1_ready); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL shl_idle_busy: got %b expected 0", bus.busy); end
    tick();
    clear_reqs();
    #1;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL shl_load_busy: got %b expected 1", bus.busy); end
    vectors++; if (bus.reg_control !== 3'd1) begin miscompares++; $display("[TB] FAIL shl_load_ctrl: got %0d expected 1", bus.reg_control); end
    vectors++; if (bus.reg_data_in !== 4'b1011) begin miscompares++; $display("[TB] FAIL shl_load_data: got %b expected 1011", bus.reg_data_in); end
    vectors++; if (bus.req0_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL shl_load_ready0: got %b expected 0", bus.req0_ready); end
    tick();
    #1;
    vectors++; if (bus.reg_control !== 3'd2) begin miscompares++; $display("[TB] FAIL shl_shift_ctrl: got %0d expected 2", bus.reg_control); end
    vectors++; if (bus.reg_data_in !== 4'h0) begin miscompares++; $display("[TB] FAIL shl_shift_data: got %b expected 0000", bus.reg_data_in); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL shl_shift_done: got %b expected 0", bus.done); end
    tick();
    #1;
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("[TB] FAIL shl_done: got %b expected 1", bus.done); end
    vectors++; if (bus.done_id !== 1'b0) begin miscompares++; $display("[TB] FAIL shl_done_id: got %b expected 0", bus.done_id); end
    vectors++; if (bus.result !== 4'b0110) begin miscompares++; $display("[TB] FAIL shl_result: got %b expected 0110", bus.result); end
    vectors++; if (bus.reg_control !== 3'd0) begin miscompares++; $display("[TB] FAIL shl_done_ctrl: got %0d expected 0", bus.reg_control); end
    tick();
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL shl_after_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.result !== 4'h0) begin miscompares++; $display("[TB] FAIL shl_after_result: got %b expected 0000", bus.result); end
  endtask

  task automatic test_shr();
    int busy_cycles;
    int done_at;
    busy_cycles = 0;
    done_at = -1;
    set_req1(2'b10, 4'b1011, 3'd2);
    #1;
    vectors++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL shr_ready1: got %b expected 1", bus.req1_ready); end
    vectors++; if (bus.req0_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL shr_ready0: got %b expected 0", bus.req0_ready); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) clear_reqs();
      #1;
      if (bus.busy === 1'b1) busy_cycles++;
      if (i == 1 || i == 2) begin
        vectors++; if (bus.reg_control !== 3'd3) begin miscompares++; $display("[TB] FAIL shr_ctrl_%0d: got %0d expected 3", i, bus.reg_control); end
      end
      if (bus.done === 1'b1) begin
        done_at = i;
        vectors++; if (bus.result !== 4'b0010) begin miscompares++; $display("[TB] FAIL shr_result: got %b expected 0010", bus.result); end
        vectors++; if (bus.done_id !== 1'b1) begin miscompares++; $display("[TB] FAIL shr_done_id: got %b expected 1", bus.done_id); end
      end
    end
    vectors++; if (busy_cycles != 4) begin miscompares++; $display("[TB] FAIL shr_busy_cycles: got %0d expected 4", busy_cycles); end
    vectors++; if (done_at != 3) begin miscompares++; $display("[TB] FAIL shr_done_cycle: got %0d expected 3", done_at); end
  endtask

  task automatic test_rol();
    logic [3:0] seen [3];
    int done_at;
    seen[0] = 4'b1001;
    seen[1] = 4'b0011;
    seen[2] = 4'b0110;
    done_at = -1;
    set_req0(2'b11, 4'b1001, 3'd3);
    #1;
    vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rol_ready0: got %b expected 1", bus.req0_ready); end
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) clear_reqs();
      #1;
      if (i >= 1 && i <= 3) begin
        vectors++; if (bus.reg_control !== 3'd4) begin miscompares++; $display("[TB] FAIL rol_ctrl_%0d: got %0d expected 4", i, bus.reg_control); end
        vectors++; if (bus.reg_data_out !== seen[i-1]) begin miscompares++; $display("[TB] FAIL rol_reg_%0d: got %b expected %b", i, bus.reg_data_out, seen[i-1]); end
      end
      if (bus.done === 1'b1) begin
        done_at = i;
        vectors++; if (bus.result !== 4'b1100) begin miscompares++; $display("[TB] FAIL rol_result: got %b expected 1100", bus.result); end
        vectors++; if (bus.done_id !== 1'b0) begin miscompares++; $display("[TB] FAIL rol_done_id: got %b expected 0", bus.done_id); end
      end
    end
    vectors++; if (done_at != 4) begin miscompares++; $display("[TB] FAIL rol_done_cycle: got %0d expected 4", done_at); end
  endtask

  // Jobs that must skip SHIFT (op 00 with a count, or a shift op with count 0),
  // then jobs whose count exceeds the register width.
  task automatic test_count_edges();
    logic [1:0] ops    [5];
    logic [3:0] datas  [5];
    logic [2:0] counts [5];
    logic [3:0] exps   [5];
    int         lat    [5];
    int done_at;
    ops[0] = 2'b00; datas[0] = 4'b0101; counts[0] = 3'd5; exps[0] = 4'b0101; lat[0] = 1;
    ops[1] = 2'b01; datas[1] = 4'b1110; counts[1] = 3'd0; exps[1] = 4'b1110; lat[1] = 1;
    ops[2] = 2'b01; datas[2] = 4'b1111; counts[2] = 3'd5; exps[2] = 4'b0000; lat[2] = 6;
    ops[3] = 2'b11; datas[3] = 4'b0110; counts[3] = 3'd5; exps[3] = 4'b1100; lat[3] = 6;
    ops[4] = 2'b10; datas[4] = 4'b1111; counts[4] = 3'd7; exps[4] = 4'b0000; lat[4] = 8;
    for (int j = 0; j < 5; j++) begin
      done_at = -1;
      set_req0(ops[j], datas[j], counts[j]);
      #1;
      vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL edge%0d_ready0: got %b expected 1", j, bus.req0_ready); end
      for (int i = 0; i < 12; i++) begin
        tick();
        if (i == 0) clear_reqs();
        #1;
        if (bus.done === 1'b1) begin
          done_at = i;
          vectors++; if (bus.result !== exps[j]) begin miscompares++; $display("[TB] FAIL edge%0d_result: got %b expected %b", j, bus.result, exps[j]); end
        end
      end
      vectors++; if (done_at != lat[j]) begin miscompares++; $display("[TB] FAIL edge%0d_done_cycle: got %0d expected %0d", j, done_at, lat[j]); end
    end
  endtask

  task automatic test_back_to_back();
    int grant_ids [8];
    int ngrants;
    int ndone;
    ngrants = 0;
    ndone = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req0(2'b01, 4'b0001, 3'd1);
    set_req1(2'b10, 4'b1000, 3'd1);
    #1;
    for (int c = 0; c < 16; c++) begin
      if (c != 0) begin
        tick();
        #1;
      end
      vectors++; if (bus.req0_ready === 1'b1 && bus.req1_ready === 1'b1) begin miscompares++; $display("[TB] FAIL rr_both_ready_c%0d: got 11 expected at most one", c); end
      if ((bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) && ngrants < 8) begin
        grant_ids[ngrants] = (bus.req1_ready === 1'b1) ? 1 : 0;
        ngrants++;
      end
      if (bus.done === 1'b1) begin
        vectors++; if (bus.done_id !== ndone[0]) begin miscompares++; $display("[TB] FAIL rr_done_id_%0d: got %b expected %b", ndone, bus.done_id, ndone[0]); end
        vectors++; if (bus.result !== (ndone[0] ? 4'b0100 : 4'b0010)) begin miscompares++; $display("[TB] FAIL rr_result_%0d: got %b expected %b", ndone, bus.result, (ndone[0] ? 4'b0100 : 4'b0010)); end
        ndone++;
      end
    end
    clear_reqs();
    vectors++; if (ngrants != 4) begin miscompares++; $display("[TB] FAIL rr_grants: got %0d expected 4", ngrants); end
    vectors++; if (ndone != 4) begin miscompares++; $display("[TB] FAIL rr_dones: got %0d expected 4", ndone); end
    for (int k = 0; k < 4; k++) begin
      if (k < ngrants) begin
        vectors++; if (grant_ids[k] != (k % 2)) begin miscompares++; $display("[TB] FAIL rr_order_%0d: got %0d expected %0d", k, grant_ids[k], k % 2); end
      end
    end
    tick();
    tick();
  endtask

  task automatic test_reset_abort();
    int dones_seen;
    int done_at;
    dones_seen = 0;
    done_at = -1;
    set_req0(2'b01, 4'b1111, 3'd7);
    #1;
    vectors++; if (bus.req0_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_ready0: got %b expected 1", bus.req0_ready); end
    tick();
    clear_reqs();
    tick();
    tick();
    #1;
    vectors++; if (bus.reg_control !== 3'd2) begin miscompares++; $display("[TB] FAIL abort_pre_ctrl: got %0d expected 2", bus.reg_control); end
    rst = 1'b1;
    tick();
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_done: got %b expected 0", bus.done); end
    vectors++; if (bus.reg_control !== 3'd0) begin miscompares++; $display("[TB] FAIL abort_ctrl: got %0d expected 0", bus.reg_control); end
    vectors++; if (bus.reg_data_in !== 4'h0) begin miscompares++; $display("[TB] FAIL abort_data_in: got %b expected 0000", bus.reg_data_in); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      if (bus.done === 1'b1) dones_seen++;
    end
    vectors++; if (dones_seen != 0) begin miscompares++; $display("[TB] FAIL abort_no_done: got %0d expected 0", dones_seen); end
    set_req1(2'b11, 4'b1000, 3'd1);
    #1;
    vectors++; if (bus.req1_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_next_ready1: got %b expected 1", bus.req1_ready); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) clear_reqs();
      #1;
      if (bus.done === 1'b1) begin
        done_at = i;
        vectors++; if (bus.result !== 4'b0001) begin miscompares++; $display("[TB] FAIL abort_next_result: got %b expected 0001", bus.result); end
        vectors++; if (bus.done_id !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_next_id: got %b expected 1", bus.done_id); end
      end
    end
    vectors++; if (done_at != 2) begin miscompares++; $display("[TB] FAIL abort_next_done_cycle: got %0d expected 2", done_at); end
  endtask

  initial begin
    clear_reqs();
    $display("[TB] starting reg_op_sequencer bench");
    test_reset();
    test_shl();
    test_shr();
    test_rol();
    test_count_edges();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
Two-requester controller that shares the single 4-bit load/shift register and sequences multi-step jobs on it. Each requester submits a job: load a value, then shift or rotate it N times. The block arbitrates between requesters round-robin, drives the register's data_in/control ports cycle by cycle, and returns the register's data_out as the job result. The register itself sits outside this block; only its port-level contract is used.

Parameters:
WIDTH, 4, register data width
COUNT_W, 3, width of shift-count field (max 2^COUNT_W-1 steps per job)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has a job
req0_op  input  2  00 load-only, 01 load+SHL, 10 load+SHR, 11 load+ROL
req0_data  input  WIDTH  value to load
req0_count  input  COUNT_W  number of shift/rotate steps
req0_ready  output  1  job from requester 0 accepted this cycle
req1_valid, req1_op, req1_data, req1_count, req1_ready  same as requester 0
reg_data_out  input  WIDTH  register current value
reg_data_in  output  WIDTH  register data input
reg_control  output  3  register control code
busy  output  1  job in progress (state != IDLE)
done  output  1  one-cycle pulse: result valid
done_id  output  1  requester that owns the completing job
result  output  WIDTH  equals reg_data_out while done=1, else 0

Behaviour:
- Register control codes: 3'd0 HOLD, 3'd1 LOAD (data_in), 3'd2 SHL (LSB<-0), 3'd3 SHR (MSB<-0), 3'd4 ROL; codes 5-7 are never driven.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: reg_control=HOLD, reg_data_in=0. If any valid, pick winner; winner's readyN=1 (combinational, IDLE only, never both). At that edge latch op, data, count, id; go to LOAD.
- Arbitration: round-robin on last-granted pointer. One valid -> it wins. Both valid -> the one not granted last wins. Pointer reset so req0 wins the first tie.
- LOAD: reg_control=LOAD, reg_data_in=latched data. Next: SHIFT if op!=00 and count!=0, else DONE. The step counter loads with count.
- SHIFT: reg_control=SHL/SHR/ROL per op, reg_data_in=0. Counter decrements each cycle. Leave to DONE in the cycle the counter reaches 1, so exactly count shift cycles are issued.
- DONE: reg_control=HOLD, done=1, done_id=latched id, result=reg_data_out. Next: IDLE. No grant is made in DONE.
- Latency: accept edge -> 1 LOAD + count SHIFT + 1 DONE. Job occupies 3+count cycles including the grant cycle.
- count > WIDTH is legal; all steps are issued (SHL/SHR give 0, ROL wraps).
- Requesters hold valid/op/data/count stable until ready. Inputs are ignored outside IDLE. Dropping valid before ready withdraws the request.
- Reset (any state, takes priority): state IDLE, pointer=req0-first, counter=0, latched fields=0. All outputs 0 next cycle (reg_control=HOLD). An aborted job produces no done. The register contents are left as-is.
- busy=1 in LOAD, SHIFT and DONE.

Test Plan:
- req0 op=01 data=1011 count=1 -> ready0 at T; LOAD at T+1; SHL at T+2; done at T+3 with result=0110, done_id=0.
- req1 op=10 data=1011 count=2 -> two SHR cycles; done result=0010, done_id=1; busy high for 4 cycles.
- req0 op=11 data=1001 count=3 -> ROL sequence 0011, 0110, 1100; result=1100.
- req0 op=00 (or count=0) data=0101 -> no SHIFT state; done two cycles after grant, result=0101.
- Both valid continuously after reset -> grants alternate req0, req1, req0 …; done_id alternates; never both ready.
- rst=1 during SHIFT of a count=7 job -> next cycle busy=0, done=0, reg_control=HOLD; no done for that job; the next job starts normally.
